ffmul_io_seq: RTL and testbench
===============================

Name: ffmul_io_seq

Overview:
- Upstream sequencer and operand/result buffer for the binary-field multiplier `ffmul` (default WIDTH=409).
- Core side: a narrow XLEN-wide word interface. The core loads operands A, B and the reduction polynomial word by word, then issues start.
- The block clears the multiplier, holds enable through the whole operation and captures the result on the finish pulse.
- The core then reads the result back word by word. A watchdog flags a hung multiplier.

Parameters:
- WIDTH, 409: field element width in bits; polynomial is WIDTH-1 bits.
- XLEN, 32: core data word width.
- NWORDS, ceil(WIDTH/XLEN) = 13: derived localparam, words per element.
- TIMEOUT, 1023: maximum RUN cycles before error.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- wr_en_i  in  1  word write strobe
- wr_sel_i  in  2  0=A, 1=B, 2=poly, 3=reserved (ignored)
- wr_idx_i  in  4  word index
- wr_data_i  in  XLEN  write data
- start_i  in  1  start request, level-sampled
- rd_en_i  in  1  result read strobe
- rd_idx_i  in  4  result word index
- rd_data_o  out  XLEN  read data, registered
- rd_valid_o  out  1  rd_data_o valid
- busy_o  out  1  operation in progress
- done_o  out  1  result available (sticky)
- done_p_o  out  1  one-cycle completion pulse
- error_o  out  1  last operation timed out (sticky)
- mul_a_o  out  WIDTH  operand A to multiplier
- mul_b_o  out  WIDTH  operand B to multiplier
- mul_poly_o  out  WIDTH-1  polynomial to multiplier
- mul_enable_o  out  1  multiplier enable
- mul_rst_n_o  out  1  multiplier active-low clear
- mul_result_i  in  WIDTH  multiplier result
- mul_finish_i  in  1  multiplier finish level (unused except sanity assertion)
- mul_finish_p_i  in  1  multiplier finish pulse

Behaviour:
- Reset (rst=1 at a clock edge):
  - state=IDLE; A, B, poly and result registers = 0.
  - rd_data_o=0; rd_valid_o, busy_o, done_o, done_p_o, error_o, mul_enable_o = 0.
  - mul_rst_n_o = 0 while rst is high.
  - Reset mid-operation aborts immediately; no result is captured.
- Writes:
  - Accepted only in IDLE or DONE. Word k maps to bits [k*XLEN +: XLEN].
  - Bits at or above WIDTH (A/B) or WIDTH-1 (poly) are discarded. With defaults, word 12 keeps 25 bits for A/B and 24 bits for poly.
  - Ignored when: busy, wr_idx_i >= NWORDS, or wr_sel_i=3.
  - Operand registers drive mul_*_o continuously.
- FSM states: IDLE, CLEAR, RUN, DONE.
  - IDLE/DONE with start_i=1 -> CLEAR.
    - done_o and error_o clear at this edge.
    - A write in the same cycle as start is applied before CLEAR.
  - CLEAR (exactly 1 cycle):
    - mul_rst_n_o=0, mul_enable_o=0, busy_o=1; watchdog := 0.
    - -> RUN.
  - RUN:
    - mul_rst_n_o=1, mul_enable_o=1, busy_o=1; watchdog increments each cycle.
    - On mul_finish_p_i=1: result register := mul_result_i (same edge); -> DONE; done_p_o=1 for the next cycle only.
    - Else if watchdog == TIMEOUT-1: result := 0; error_o := 1; -> DONE; done_p_o pulses.
    - If finish pulse and timeout coincide, the finish pulse wins (no error).
  - DONE:
    - done_o=1; mul_enable_o=0; mul_rst_n_o=1.
    - Multiplier state is left as-is until the next CLEAR.
- start_i while busy (CLEAR/RUN) is ignored, not queued.
- mul_finish_p_i outside RUN is ignored.
- Reads:
  - 1-cycle latency: rd_en_i at edge k gives rd_data_o and rd_valid_o=1 after edge k.
  - rd_valid_o is low the cycle after rd_en_i=0.
  - Returns the result word, upper unused bits zero.
  - rd_idx_i >= NWORDS returns 0 with rd_valid_o=1.
  - Reads are allowed in any state and return the last captured result (0 after reset).
- Minimum latency: start edge -> CLEAR -> RUN; done_p_o follows the edge on which mul_finish_p_i is seen.

Decomposition:
- Package ffmul_pkg holds:
  - state enum fsm_state_e {IDLE, CLEAR, RUN, DONE};
  - wr_sel encodings SEL_A, SEL_B, SEL_POLY;
  - default XLEN and WIDTH constants;
  - function nwords(width, xlen).
- One sub-module: ffmul_word_reg, a parameterised WIDTH-bit register with word-indexed write and masking. Instantiated three times (A, B, poly). Result readback mux stays in the top.

Test Plan:
- Write A word0=0x1, B word0=0x2, poly word0=0x1 (x^408+1 implicit in multiplier), start; bench model pulses mul_finish_p_i after 20 RUN cycles with result=0x2.
  -> busy_o high for 22 cycles; done_p_o single pulse; reading idx0 gives rd_data_o=0x2 next cycle; idx1..12 give 0.
- Write A word12=0xFFFFFFFF -> mul_a_o[408:384]=25'h1FFFFFF and nothing above; poly word12=0xFFFFFFFF -> mul_poly_o[407:384]=24'hFFFFFF.
- Start while model never finishes -> error_o=1 and done_p_o pulse exactly 1023 RUN cycles later; result reads 0; a new start clears error_o.
- Write and start during RUN -> operands unchanged, no second CLEAR; rd_idx_i=13 -> rd_data_o=0, rd_valid_o=1.
- rst asserted in RUN cycle 5 -> next cycle IDLE, mul_enable_o=0, mul_rst_n_o=0, all outputs 0; subsequent full operation completes normally.
- mul_finish_p_i coincides with watchdog expiry -> result captured, error_o=0.

Source files
------------

// File: rtl/ffmul_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ffmul_pkg
// Description : Shared types, encodings and helpers for the ffmul sequencer
//               and its operand registers.
// Revision    : 1.0 - initial release
// ============================================================================
package ffmul_pkg;

    // Sequencer states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        RUN   = 2'd2,
        DONE  = 2'd3
    } fsm_state_e;

    // Core-side write target selection (value 3 is reserved and ignored)
    localparam logic [1:0] SEL_A    = 2'd0;
    localparam logic [1:0] SEL_B    = 2'd1;
    localparam logic [1:0] SEL_POLY = 2'd2;

    localparam int DEF_XLEN  = 32;
    localparam int DEF_WIDTH = 409;

    // Number of XLEN-wide words needed to hold a WIDTH-bit value
    function automatic int nwords(input int width, input int xlen);
        return (width + xlen - 1) / xlen;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ffmul_word_reg.sv
`default_nettype none
// ============================================================================
// Module      : ffmul_word_reg
// Description : WIDTH-bit register loaded one XLEN-wide word at a time. The
//               last word keeps only the bits that fall below WIDTH.
// Revision    : 1.0 - initial release
// ============================================================================
module ffmul_word_reg
    import ffmul_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int XLEN  = DEF_XLEN,
    parameter int IDXW  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en_i,
    input  logic [IDXW-1:0]  wr_idx_i,
    input  logic [XLEN-1:0]  wr_data_i,
    output logic [WIDTH-1:0] data_o
);

    localparam int c_nw = nwords(WIDTH, XLEN);

    // One independent slice per word; indices with no matching slice are dropped
    for (genvar w = 0; w < c_nw; w++) begin : g_word
        localparam int c_lo   = w * XLEN;
        localparam int c_bits = ((WIDTH - c_lo) < XLEN) ? (WIDTH - c_lo) : XLEN;
        localparam logic [IDXW-1:0] c_idx = IDXW'(w);

        logic [c_bits-1:0] word_q;

        // Load this word when addressed; high bits of a partial word are discarded
        always_ff @(posedge clk) begin
            if (rst) begin
                word_q <= '0;
            end else if (wr_en_i && (wr_idx_i == c_idx)) begin
                word_q <= wr_data_i[c_bits-1:0];
            end
        end

        assign data_o[c_lo +: c_bits] = word_q;
    end

endmodule
`default_nettype wire

// File: rtl/ffmul_io_seq.sv
`default_nettype none
// ============================================================================
// Module      : ffmul_io_seq
// Description : Word-wide operand loader, start/clear/run sequencer, result
//               capture and word readback for the ffmul binary-field
//               multiplier, with a watchdog on the run phase.
// Revision    : 1.0 - initial release
// ============================================================================
module ffmul_io_seq
    import ffmul_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int XLEN    = DEF_XLEN,
    parameter int TIMEOUT = 1023
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en_i,
    input  logic [1:0]       wr_sel_i,
    input  logic [3:0]       wr_idx_i,
    input  logic [XLEN-1:0]  wr_data_i,
    input  logic             start_i,
    input  logic             rd_en_i,
    input  logic [3:0]       rd_idx_i,
    output logic [XLEN-1:0]  rd_data_o,
    output logic             rd_valid_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             done_p_o,
    output logic             error_o,
    output logic [WIDTH-1:0] mul_a_o,
    output logic [WIDTH-1:0] mul_b_o,
    output logic [WIDTH-2:0] mul_poly_o,
    output logic             mul_enable_o,
    output logic             mul_rst_n_o,
    input  logic [WIDTH-1:0] mul_result_i,
    input  logic             mul_finish_i,
    input  logic             mul_finish_p_i
);

    localparam int NWORDS = nwords(WIDTH, XLEN);
    localparam int c_wdw  = $clog2(TIMEOUT + 1);
    localparam logic [c_wdw-1:0] c_wd_last = c_wdw'(TIMEOUT - 1);
    localparam logic [4:0]       c_nw_idx  = 5'(NWORDS);

    fsm_state_e        state_q, state_d;
    logic [c_wdw-1:0]  wd_q, wd_d;
    logic [WIDTH-1:0]  result_q, result_d;
    logic              error_q, error_d;
    logic              done_p_q, done_p_d;
    logic [XLEN-1:0]   rd_data_q;
    logic              rd_valid_q;

    logic              w_wr_ok;
    logic [XLEN-1:0]   w_rd_word;
    logic [NWORDS*XLEN-1:0] w_res_pad;
    logic [XLEN-1:0]   w_res_words [NWORDS];

    // Operand writes only land while no operation is in flight
    assign w_wr_ok = wr_en_i
                   && ((state_q == IDLE) || (state_q == DONE))
                   && ({1'b0, wr_idx_i} < c_nw_idx);

    ffmul_word_reg #(.WIDTH(WIDTH), .XLEN(XLEN), .IDXW(4)) u_reg_a (
        .clk       (clk),
        .rst       (rst),
        .wr_en_i   (w_wr_ok && (wr_sel_i == SEL_A)),
        .wr_idx_i  (wr_idx_i),
        .wr_data_i (wr_data_i),
        .data_o    (mul_a_o)
    );

    ffmul_word_reg #(.WIDTH(WIDTH), .XLEN(XLEN), .IDXW(4)) u_reg_b (
        .clk       (clk),
        .rst       (rst),
        .wr_en_i   (w_wr_ok && (wr_sel_i == SEL_B)),
        .wr_idx_i  (wr_idx_i),
        .wr_data_i (wr_data_i),
        .data_o    (mul_b_o)
    );

    ffmul_word_reg #(.WIDTH(WIDTH - 1), .XLEN(XLEN), .IDXW(4)) u_reg_poly (
        .clk       (clk),
        .rst       (rst),
        .wr_en_i   (w_wr_ok && (wr_sel_i == SEL_POLY)),
        .wr_idx_i  (wr_idx_i),
        .wr_data_i (wr_data_i),
        .data_o    (mul_poly_o)
    );

    // Next state, watchdog, result capture and completion flags
    always_comb begin
        state_d  = state_q;
        wd_d     = wd_q;
        result_d = result_q;
        error_d  = error_q;
        done_p_d = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                if (start_i) begin
                    state_d = CLEAR;
                    error_d = 1'b0;
                end
            end
            CLEAR: begin
                wd_d    = '0;
                state_d = RUN;
            end
            RUN: begin
                wd_d = wd_q + 1'b1;
                // A finish pulse beats a simultaneous watchdog expiry
                if (mul_finish_p_i) begin
                    result_d = mul_result_i;
                    state_d  = DONE;
                    done_p_d = 1'b1;
                end else if (wd_q == c_wd_last) begin
                    result_d = '0;
                    error_d  = 1'b1;
                    state_d  = DONE;
                    done_p_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Sequencer state registers; reset aborts any operation without capture
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            wd_q     <= '0;
            result_q <= '0;
            error_q  <= 1'b0;
            done_p_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            wd_q     <= wd_d;
            result_q <= result_d;
            error_q  <= error_d;
            done_p_q <= done_p_d;
        end
    end

    // Result split into zero-padded words for readback
    assign w_res_pad = (NWORDS*XLEN)'(result_q);
    for (genvar w = 0; w < NWORDS; w++) begin : g_res_word
        assign w_res_words[w] = w_res_pad[w*XLEN +: XLEN];
    end

    assign w_rd_word = ({1'b0, rd_idx_i} < c_nw_idx) ? w_res_words[rd_idx_i] : '0;

    // Registered read port, one cycle behind the strobe
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= rd_en_i;
            if (rd_en_i) begin
                rd_data_q <= w_rd_word;
            end
        end
    end

    assign rd_data_o    = rd_data_q;
    assign rd_valid_o   = rd_valid_q;
    assign busy_o       = (state_q == CLEAR) || (state_q == RUN);
    assign done_o       = (state_q == DONE);
    assign done_p_o     = done_p_q;
    assign error_o      = error_q;
    assign mul_enable_o = (state_q == RUN);
    // The multiplier is held in clear during our own reset and the CLEAR cycle
    assign mul_rst_n_o  = !rst && (state_q != CLEAR);

    // A finish pulse during RUN should come with the finish level raised
    a_finish_level : assert property (@(posedge clk) disable iff (rst)
        ((state_q == RUN) && mul_finish_p_i) |-> mul_finish_i);

endmodule
`default_nettype wire

// File: tb/tb_ffmul_io_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_ffmul_io_seq
// Description : Directed self-checking bench for ffmul_io_seq with a simple
//               multiplier stand-in driven from the stimulus sequence.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ffmul_io_seq;

    localparam int W = 409;
    localparam int X = 32;

    logic           clk = 1'b0;
    logic           rst;
    logic           wr_en_i;
    logic [1:0]     wr_sel_i;
    logic [3:0]     wr_idx_i;
    logic [X-1:0]   wr_data_i;
    logic           start_i;
    logic           rd_en_i;
    logic [3:0]     rd_idx_i;
    logic [X-1:0]   rd_data_o;
    logic           rd_valid_o;
    logic           busy_o;
    logic           done_o;
    logic           done_p_o;
    logic           error_o;
    logic [W-1:0]   mul_a_o;
    logic [W-1:0]   mul_b_o;
    logic [W-2:0]   mul_poly_o;
    logic           mul_enable_o;
    logic           mul_rst_n_o;
    logic [W-1:0]   mul_result_i;
    logic           mul_finish_i;
    logic           mul_finish_p_i;

    int n_checks = 0;
    int n_fail   = 0;

    ffmul_io_seq #(.WIDTH(W), .XLEN(X), .TIMEOUT(1023)) dut (
        .clk            (clk),
        .rst            (rst),
        .wr_en_i        (wr_en_i),
        .wr_sel_i       (wr_sel_i),
        .wr_idx_i       (wr_idx_i),
        .wr_data_i      (wr_data_i),
        .start_i        (start_i),
        .rd_en_i        (rd_en_i),
        .rd_idx_i       (rd_idx_i),
        .rd_data_o      (rd_data_o),
        .rd_valid_o     (rd_valid_o),
        .busy_o         (busy_o),
        .done_o         (done_o),
        .done_p_o       (done_p_o),
        .error_o        (error_o),
        .mul_a_o        (mul_a_o),
        .mul_b_o        (mul_b_o),
        .mul_poly_o     (mul_poly_o),
        .mul_enable_o   (mul_enable_o),
        .mul_rst_n_o    (mul_rst_n_o),
        .mul_result_i   (mul_result_i),
        .mul_finish_i   (mul_finish_i),
        .mul_finish_p_i (mul_finish_p_i)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Inputs change and outputs are sampled at the falling edge
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wr(input logic [1:0] sel, input logic [3:0] idx, input logic [X-1:0] data);
        wr_en_i   = 1'b1;
        wr_sel_i  = sel;
        wr_idx_i  = idx;
        wr_data_i = data;
        tick();
        wr_en_i   = 1'b0;
    endtask

    task automatic rd(input logic [3:0] idx, output logic [X-1:0] d, output logic v);
        rd_en_i  = 1'b1;
        rd_idx_i = idx;
        tick();
        rd_en_i  = 1'b0;
        d = rd_data_o;
        v = rd_valid_o;
    endtask

    // Start an operation; the stand-in multiplier pulses finish in RUN cycle
    // fin_at (0 = never). Returns busy/RUN cycle counts and done pulse stats.
    task automatic run_op(input int fin_at, input logic [W-1:0] res,
                          output int busy_n, output int run_n,
                          output int dp_n, output logic dp_now);
        busy_n = 0;
        run_n  = 0;
        dp_n   = 0;
        mul_finish_i = 1'b0;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        for (int i = 0; i < 1200 && !done_o; i++) begin
            if (busy_o) busy_n++;
            if (mul_enable_o) begin
                run_n++;
                if (run_n == fin_at) begin
                    mul_finish_p_i = 1'b1;
                    mul_finish_i   = 1'b1;
                    mul_result_i   = res;
                end
            end
            tick();
            mul_finish_p_i = 1'b0;
            if (done_p_o) dp_n++;
        end
        dp_now = done_p_o;
        chk("op_complete", done_o, 1);
        for (int i = 0; i < 3; i++) begin
            tick();
            if (done_p_o) dp_n++;
        end
    endtask

    logic [X-1:0] d;
    logic         v;
    logic [X-1:0] acc;
    int           bn, rn, dpn;
    logic         dpnow;

    initial begin
        rst = 1'b1;
        wr_en_i = 1'b0; wr_sel_i = '0; wr_idx_i = '0; wr_data_i = '0;
        start_i = 1'b0; rd_en_i = 1'b0; rd_idx_i = '0;
        mul_result_i = '0; mul_finish_i = 1'b0; mul_finish_p_i = 1'b0;
        tick();
        tick();

        // Reset state
        chk("rst_busy",  busy_o, 0);
        chk("rst_done",  done_o, 0);
        chk("rst_donep", done_p_o, 0);
        chk("rst_err",   error_o, 0);
        chk("rst_en",    mul_enable_o, 0);
        chk("rst_mrstn", mul_rst_n_o, 0);
        chk("rst_rdv",   rd_valid_o, 0);
        chk("rst_rdd",   rd_data_o, 0);
        chk("rst_a",     mul_a_o, 0);
        rst = 1'b0;
        tick();
        rd(4'd0, d, v);
        chk("rd_after_rst", d, 0);
        chk("rd_after_rst_v", v, 1);
        tick();
        chk("rd_valid_drop", rd_valid_o, 0);

        // Basic operation: finish in RUN cycle 21, result 0x2
        wr(2'd0, 4'd0, 32'h1);
        wr(2'd1, 4'd0, 32'h2);
        wr(2'd2, 4'd0, 32'h1);
        chk("t1_a", mul_a_o, 1);
        chk("t1_b", mul_b_o, 2);
        chk("t1_poly", mul_poly_o, 1);
        run_op(21, W'(2), bn, rn, dpn, dpnow);
        chk("t1_busy_cycles", bn, 22);
        chk("t1_run_cycles", rn, 21);
        chk("t1_dp_count", dpn, 1);
        chk("t1_dp_edge", dpnow, 1);
        chk("t1_err", error_o, 0);
        chk("t1_done", done_o, 1);
        chk("t1_en_off", mul_enable_o, 0);
        chk("t1_mrstn", mul_rst_n_o, 1);
        rd(4'd0, d, v);
        chk("t1_rd0", d, 32'h2);
        acc = '0;
        for (int i = 1; i < 13; i++) begin
            rd(4'(i), d, v);
            acc = acc | d;
        end
        chk("t1_rd_upper_zero", acc, 0);

        // Top-word masking and ignored writes
        wr(2'd0, 4'd12, 32'hFFFF_FFFF);
        chk("t2_a_top", mul_a_o, {25'h1FF_FFFF, 383'd0, 1'b1});
        wr(2'd2, 4'd12, 32'hFFFF_FFFF);
        chk("t2_poly_top", mul_poly_o, {24'hFF_FFFF, 383'd0, 1'b1});
        wr(2'd3, 4'd0, 32'hABCD);
        wr(2'd0, 4'd13, 32'h55);
        chk("t2_a_kept", mul_a_o, {25'h1FF_FFFF, 383'd0, 1'b1});
        chk("t2_b_kept", mul_b_o, 2);
        chk("t2_poly_kept", mul_poly_o, {24'hFF_FFFF, 383'd0, 1'b1});

        // Watchdog expiry
        run_op(0, '0, bn, rn, dpn, dpnow);
        chk("t3_run_cycles", rn, 1023);
        chk("t3_err", error_o, 1);
        chk("t3_dp_count", dpn, 1);
        chk("t3_dp_edge", dpnow, 1);
        rd(4'd0, d, v);
        chk("t3_rd0", d, 0);

        // Restart clears error; write/start during RUN ignored; reset in RUN
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        chk("t4_err_cleared", error_o, 0);
        chk("t4_clear_mrstn", mul_rst_n_o, 0);
        tick();
        tick();
        wr_en_i = 1'b1; wr_sel_i = 2'd0; wr_idx_i = 4'd0; wr_data_i = 32'hDEAD;
        start_i = 1'b1;
        tick();
        wr_en_i = 1'b0;
        start_i = 1'b0;
        chk("t4_a_unchanged", mul_a_o, {25'h1FF_FFFF, 383'd0, 1'b1});
        chk("t4_no_reclear", mul_rst_n_o, 1);
        chk("t4_still_run", mul_enable_o, 1);
        tick();
        tick();
        rst = 1'b1;
        tick();
        chk("t4_rst_busy", busy_o, 0);
        chk("t4_rst_en", mul_enable_o, 0);
        chk("t4_rst_mrstn", mul_rst_n_o, 0);
        chk("t4_rst_done", done_o, 0);
        chk("t4_rst_donep", done_p_o, 0);
        chk("t4_rst_a", mul_a_o, 0);
        rst = 1'b0;
        tick();

        // Full operation after reset
        wr(2'd0, 4'd0, 32'h3);
        wr(2'd1, 4'd0, 32'h5);
        wr(2'd2, 4'd0, 32'h1);
        run_op(21, W'(64'h0000_0012_3456_789A), bn, rn, dpn, dpnow);
        chk("t5_busy_cycles", bn, 22);
        chk("t5_err", error_o, 0);
        chk("t5_dp_count", dpn, 1);
        rd(4'd0, d, v);
        chk("t5_rd0", d, 32'h3456_789A);
        rd(4'd1, d, v);
        chk("t5_rd1", d, 32'h12);

        // Finish pulse coinciding with watchdog expiry
        run_op(1023, {W{1'b1}}, bn, rn, dpn, dpnow);
        chk("t6_run_cycles", rn, 1023);
        chk("t6_err", error_o, 0);
        chk("t6_dp_count", dpn, 1);
        rd(4'd12, d, v);
        chk("t6_rd12", d, 32'h01FF_FFFF);
        rd(4'd0, d, v);
        chk("t6_rd0", d, 32'hFFFF_FFFF);
        rd(4'd13, d, v);
        chk("t6_rd13", d, 0);
        chk("t6_rd13_v", v, 1);

        // Finish pulse outside RUN is ignored
        mul_finish_p_i = 1'b1;
        mul_result_i   = '0;
        tick();
        mul_finish_p_i = 1'b0;
        chk("t7_no_dp", done_p_o, 0);
        rd(4'd0, d, v);
        chk("t7_result_kept", d, 32'hFFFF_FFFF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
